// File: rtl/rv32i_memtop.sv
// -----------------------------------------------------------------------------
// rv32i_memtop -- memory stage of the RV32I five-stage pipeline.
//
// Takes the EX/MEM pipeline register and performs loads and stores on a
// req/ack data bus with an abort timeout. It aligns and extends load data,
// stalls the upstream stages while a transfer is in flight, registers results
// towards wbTop, and forwards the MEM-stage writeback to idTop.
//
// Bus handshake: d_rd_req / d_wr_req rise on the edge that enters REQ and stay
// high, with d_addr / d_be / d_wdata held stable, until the cycle in which
// d_ack is sampled high (or the timeout fires). That cycle completes the
// transfer and the requests drop on the following edge. d_ack has no meaning
// while no request is high.
//
// Ports
//   clk, reset                  clock; synchronous active-low reset
//   pc_in, iw_in, alu_in        EX/MEM register: PC, instruction, ALU result/address
//   rs2_data_in                 store data
//   wb_reg_in, wb_en_in         destination register and writeback enable
//   w_en_in                     memory/io write enable (forwarded only)
//   d_addr, d_wdata, d_be       bus word address, lane-replicated data, byte enables
//   d_rd_req, d_wr_req          bus read / write requests
//   d_ack, d_rdata              bus completion and read data
//   mem_stall                   freeze IF/ID/EX and hold EX/MEM
//   bus_err                     one-cycle pulse on misaligned access or timeout
//   pc_out, iw_out, alu_out     registered pass-through to wbTop
//   mem_data_out                registered extended load data (0 for non-loads)
//   wb_reg_out, wb_en_out       registered writeback target and enable
//   df_mem_*                    combinational forwarding to idTop
//   dbg_state                   FSM state (0 = IDLE, 1 = REQ)
// -----------------------------------------------------------------------------
module rv32i_memtop #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_IW         = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic [31:0] iw_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] rs2_data_in,
   input  logic [4:0]  wb_reg_in,
   input  logic        wb_en_in,
   input  logic        w_en_in,
   output logic [31:0] d_addr,
   output logic [31:0] d_wdata,
   output logic [3:0]  d_be,
   output logic        d_rd_req,
   output logic        d_wr_req,
   input  logic        d_ack,
   input  logic [31:0] d_rdata,
   output logic        mem_stall,
   output logic        bus_err,
   output logic [31:0] pc_out,
   output logic [31:0] iw_out,
   output logic [31:0] alu_out,
   output logic [31:0] mem_data_out,
   output logic [4:0]  wb_reg_out,
   output logic        wb_en_out,
   output logic        df_mem_enable,
   output logic [4:0]  df_mem_reg,
   output logic [31:0] df_mem_data,
   output logic        df_w_en_mem,
   output logic        dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

   // Counter value seen during the last REQ cycle before abort.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_rd_req, r_wr_req;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_pc, r_iw, r_alu, r_mem_data;
   logic [4:0]  r_wb_reg;
   logic        r_wb_en, r_bus_err;

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic        w_load, w_store, w_misal, w_go;
   logic        w_in_req, w_timeout, w_done, w_capture;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext, w_wdata;
   logic [3:0]  w_be;

   assign w_opcode = iw_in[6:0];
   assign w_f3     = iw_in[14:12];

   assign w_load  = (w_opcode == 7'b0000011) &&
                    (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010 ||
                     w_f3 == 3'b100 || w_f3 == 3'b101);
   assign w_store = (w_opcode == 7'b0100011) &&
                    (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010);

   // f3[1:0] encodes access size for both loads and stores (00 B, 01 H, 10 W).
   assign w_misal = (w_load || w_store) &&
                    ((w_f3[1:0] == 2'b01 && alu_in[0]) ||
                     (w_f3[1:0] == 2'b10 && alu_in[1:0] != 2'b00));
   assign w_go    = (w_load || w_store) && !w_misal;

   assign w_in_req  = (r_state == S_REQ);
   // Ack wins over a coincident timeout.
   assign w_timeout = w_in_req && !d_ack && (r_cnt == TO_LAST);
   assign w_done    = w_in_req && (d_ack || w_timeout);
   assign w_capture = (!w_in_req && !w_go) || w_done;

   // Load alignment and extension from the addressed lane.
   always_comb begin
      w_byte = d_rdata[7:0];
      case (alu_in[1:0])
         2'b01:   w_byte = d_rdata[15:8];
         2'b10:   w_byte = d_rdata[23:16];
         2'b11:   w_byte = d_rdata[31:24];
         default: w_byte = d_rdata[7:0];
      endcase
      w_half = alu_in[1] ? d_rdata[31:16] : d_rdata[15:0];
      case (w_f3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b100:  w_ext = {24'h0, w_byte};
         3'b101:  w_ext = {16'h0, w_half};
         default: w_ext = d_rdata;
      endcase
   end

   // Store lanes: data is replicated so the byte enables alone pick the lane.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = rs2_data_in;
      if (w_store) begin
         case (w_f3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << alu_in[1:0];
               w_wdata = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
               w_be    = 4'b0011 << alu_in[1:0];
               w_wdata = {2{rs2_data_in[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = rs2_data_in;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 8'd0;
         r_rd_req   <= 1'b0;
         r_wr_req   <= 1'b0;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_be       <= 4'h0;
         r_pc       <= 32'h0;
         r_iw       <= 32'h0;
         r_alu      <= 32'h0;
         r_mem_data <= 32'h0;
         r_wb_reg   <= 5'd0;
         r_wb_en    <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         if (w_capture) begin
            r_pc       <= pc_in;
            r_iw       <= iw_in;
            r_alu      <= alu_in;
            r_wb_reg   <= wb_reg_in;
            // Misaligned or aborted accesses retire without writeback.
            r_wb_en    <= wb_en_in && !(w_misal && !w_in_req) && !w_timeout;
            r_mem_data <= (w_in_req && d_ack && w_load) ? w_ext : 32'h0;
            r_bus_err  <= (w_misal && !w_in_req) || w_timeout;
         end else begin
            // Bubble towards wbTop while the transfer is outstanding.
            r_iw       <= NOP_IW;
            r_wb_en    <= 1'b0;
            r_mem_data <= 32'h0;
            r_bus_err  <= 1'b0;
         end

         if (r_state == S_IDLE) begin
            if (w_go) begin
               r_state  <= S_REQ;
               r_cnt    <= 8'd0;
               r_rd_req <= w_load;
               r_wr_req <= w_store;
               r_addr   <= {alu_in[31:2], 2'b00};
               r_be     <= w_be;
               r_wdata  <= w_wdata;
            end
         end else begin
            if (w_done) begin
               r_state  <= S_IDLE;
               r_cnt    <= 8'd0;
               r_rd_req <= 1'b0;
               r_wr_req <= 1'b0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign mem_stall = (!w_in_req && w_go) || (w_in_req && !w_done);

   assign d_addr   = r_addr;
   assign d_wdata  = r_wdata;
   assign d_be     = r_be;
   assign d_rd_req = r_rd_req;
   assign d_wr_req = r_wr_req;

   assign pc_out       = r_pc;
   assign iw_out       = r_iw;
   assign alu_out      = r_alu;
   assign mem_data_out = r_mem_data;
   assign wb_reg_out   = r_wb_reg;
   assign wb_en_out    = r_wb_en;
   assign bus_err      = r_bus_err;
   assign dbg_state    = r_state;

   // A load's value is only known in the cycle its ack arrives.
   assign df_mem_enable = wb_en_in && !(w_load && !(w_in_req && d_ack));
   assign df_mem_reg    = wb_reg_in;
   assign df_mem_data   = w_load ? w_ext : alu_in;
   assign df_w_en_mem   = w_en_in;

endmodule

// File: tb/tb_rv32i_memtop.sv
// -----------------------------------------------------------------------------
// tb_rv32i_memtop -- directed bench for the RV32I memory stage.
// The driver issues one EX/MEM instruction at a time, holds it while the stage
// stalls and answers bus requests; the expected retirement record is queued on
// issue. The monitor pops a record for every edge that retires an instruction
// (reset high and mem_stall low in the cycle before) and compares outputs.
// -----------------------------------------------------------------------------
module tb_rv32i_memtop;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          EW  = 135;

   logic        clk;
   logic        reset;
   logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
   logic [4:0]  wb_reg_in;
   logic        wb_en_in, w_en_in;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        d_rd_req, d_wr_req;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_stall, bus_err;
   logic [31:0] pc_out, iw_out, alu_out, mem_data_out;
   logic [4:0]  wb_reg_out;
   logic        wb_en_out;
   logic        df_mem_enable;
   logic [4:0]  df_mem_reg;
   logic [31:0] df_mem_data;
   logic        df_w_en_mem;
   logic        dbg_state;

   rv32i_memtop #(.TIMEOUT_CYCLES(4), .NOP_IW(NOP)) dut (
      .clk(clk), .reset(reset),
      .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
      .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .w_en_in(w_en_in),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_stall(mem_stall), .bus_err(bus_err),
      .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out), .mem_data_out(mem_data_out),
      .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
      .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg),
      .df_mem_data(df_mem_data), .df_w_en_mem(df_w_en_mem),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];
   logic mon_pending = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [31:0] pc, input logic [31:0] iw,
                                        input logic [31:0] alu, input logic [31:0] md,
                                        input logic [4:0] wr, input logic wbe, input logic err);
      return {pc, iw, alu, md, wr, wbe, err};
   endfunction

   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      if (mon_pending) begin
         if (exp_q.size() == 0) begin
            chk("retire_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pc_out",       pc_out,       e[134:103]);
            chk("iw_out",       iw_out,       e[102:71]);
            chk("alu_out",      alu_out,      e[70:39]);
            chk("mem_data_out", mem_data_out, e[38:7]);
            chk("wb_reg_out",   {27'h0, wb_reg_out}, {27'h0, e[6:2]});
            chk("wb_en_out",    {31'h0, wb_en_out},  {31'h0, e[1]});
            chk("bus_err",      {31'h0, bus_err},    {31'h0, e[0]});
         end
      end
      mon_pending = reset && (mem_stall === 1'b0);
   end

   // ---------------- driver ----------------
   int          obs_stall, obs_req;
   logic        obs_rd, obs_wr, obs_stable, obs_df_en0, obs_df_en_last;
   logic [31:0] obs_addr, obs_wdata, obs_df_data_last;
   logic [3:0]  obs_be;

   // Holds one instruction until it retires; acks after ack_wait idle REQ
   // cycles (negative: never ack).
   task automatic issue(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] wr, input logic wbe,
                        input logic we, input int ack_wait, input logic [31:0] rdata,
                        input logic [EW-1:0] exp);
      bit done = 0;
      exp_q.push_back(exp);
      pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
      wb_reg_in = wr; wb_en_in = wbe; w_en_in = we;
      d_ack = 1'b0; d_rdata = 32'h0;
      obs_stall = 0; obs_req = 0; obs_rd = 0; obs_wr = 0; obs_stable = 1;
      obs_addr = 0; obs_wdata = 0; obs_be = 0;
      obs_df_en0 = 0; obs_df_en_last = 0; obs_df_data_last = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         if (d_rd_req || d_wr_req) begin
            if (obs_req == 0) begin
               obs_addr = d_addr; obs_be = d_be; obs_wdata = d_wdata;
            end else if (d_addr !== obs_addr || d_be !== obs_be || d_wdata !== obs_wdata) begin
               obs_stable = 0;
            end
            obs_rd = obs_rd | d_rd_req;
            obs_wr = obs_wr | d_wr_req;
            if (obs_req == ack_wait) begin
               d_ack = 1'b1;
               d_rdata = rdata;
            end
            obs_req++;
         end
         @(negedge clk);
         if (c == 0) obs_df_en0 = df_mem_enable;
         obs_df_en_last   = df_mem_enable;
         obs_df_data_last = df_mem_data;
         if (mem_stall === 1'b0) done = 1;
         else obs_stall++;
         @(posedge clk); #1;
         d_ack = 1'b0;
      end
      if (!done) chk("issue_cycle_budget", 32'd0, 32'd1);
   endtask

   task automatic nop(input logic [31:0] pc);
      issue(pc, NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, -1, 32'h0,
            mk(pc, NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0;
      pc_in = 0; iw_in = NOP; alu_in = 0; rs2_data_in = 0;
      wb_reg_in = 0; wb_en_in = 0; w_en_in = 0; d_ack = 0; d_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc_out",   pc_out,       32'h0);
      chk("rst_iw_out",   iw_out,       32'h0);
      chk("rst_alu_out",  alu_out,      32'h0);
      chk("rst_mem_data", mem_data_out, 32'h0);
      chk("rst_wb_en",    {31'h0, wb_en_out}, 32'h0);
      chk("rst_bus_err",  {31'h0, bus_err},   32'h0);
      chk("rst_rd_req",   {31'h0, d_rd_req},  32'h0);
      chk("rst_wr_req",   {31'h0, d_wr_req},  32'h0);
      chk("rst_state",    {31'h0, dbg_state}, 32'h0);
      reset = 1'b1;

      // ADDI x3,x0,5: single-cycle pass-through with forwarding
      issue(32'h100, 32'h0050_0193, 32'h5, 32'h0, 5'd3, 1'b1, 1'b0, -1, 32'h0,
            mk(32'h100, 32'h0050_0193, 32'h5, 32'h0, 5'd3, 1'b1, 1'b0));
      chk("addi_stall", obs_stall, 0);
      chk("addi_df_en", {31'h0, obs_df_en_last}, 32'h1);
      chk("addi_df_data", obs_df_data_last, 32'h5);

      // LB from 0x102, three wait cycles; ack lands on the timeout cycle
      issue(32'h104, 32'h0000_8283, 32'h102, 32'h0, 5'd5, 1'b1, 1'b0, 3, 32'h0080_0000,
            mk(32'h104, 32'h0000_8283, 32'h102, 32'hFFFF_FF80, 5'd5, 1'b1, 1'b0));
      chk("lb_stall", obs_stall, 4);
      chk("lb_rd_req", {31'h0, obs_rd}, 32'h1);
      chk("lb_wr_req", {31'h0, obs_wr}, 32'h0);
      chk("lb_addr", obs_addr, 32'h100);
      chk("lb_be", {28'h0, obs_be}, 32'hF);
      chk("lb_stable", {31'h0, obs_stable}, 32'h1);
      chk("lb_df_en_wait", {31'h0, obs_df_en0}, 32'h0);
      chk("lb_df_en_ack", {31'h0, obs_df_en_last}, 32'h1);
      chk("lb_df_data", obs_df_data_last, 32'hFFFF_FF80);

      // SH to 0x202
      issue(32'h108, 32'h0020_9023, 32'h202, 32'h1234_ABCD, 5'd0, 1'b0, 1'b1, 1, 32'h0,
            mk(32'h108, 32'h0020_9023, 32'h202, 32'h0, 5'd0, 1'b0, 1'b0));
      chk("sh_be", {28'h0, obs_be}, 32'hC);
      chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
      chk("sh_addr", obs_addr, 32'h200);
      chk("sh_wr_req", {31'h0, obs_wr}, 32'h1);
      chk("sh_rd_req", {31'h0, obs_rd}, 32'h0);
      chk("sh_stall", obs_stall, 2);
      chk("sh_stable", {31'h0, obs_stable}, 32'h1);

      // misaligned LW at 0x101
      issue(32'h10C, 32'h0000_A303, 32'h101, 32'h0, 5'd6, 1'b1, 1'b0, -1, 32'h0,
            mk(32'h10C, 32'h0000_A303, 32'h101, 32'h0, 5'd6, 1'b0, 1'b1));
      chk("lw_mis_stall", obs_stall, 0);
      chk("lw_mis_req", obs_req, 0);
      nop(32'h0);

      // LW with no ack: abort after four REQ cycles
      issue(32'h110, 32'h0000_A303, 32'h300, 32'h0, 5'd6, 1'b1, 1'b0, -1, 32'h0,
            mk(32'h110, 32'h0000_A303, 32'h300, 32'h0, 5'd6, 1'b0, 1'b1));
      chk("lw_to_req_cycles", obs_req, 4);
      chk("lw_to_stall", obs_stall, 4);
      nop(32'h0);

      // LHU / LH upper half at 0x302, minimum latency
      issue(32'h114, 32'h0000_D383, 32'h302, 32'h0, 5'd7, 1'b1, 1'b0, 0, 32'h8765_4321,
            mk(32'h114, 32'h0000_D383, 32'h302, 32'h0000_8765, 5'd7, 1'b1, 1'b0));
      chk("lhu_stall", obs_stall, 1);
      issue(32'h118, 32'h0000_9383, 32'h302, 32'h0, 5'd7, 1'b1, 1'b0, 0, 32'h8765_4321,
            mk(32'h118, 32'h0000_9383, 32'h302, 32'hFFFF_8765, 5'd7, 1'b1, 1'b0));

      // SB to 0x203, SW to 0x204
      issue(32'h11C, 32'h0020_8023, 32'h203, 32'h1234_56A5, 5'd0, 1'b0, 1'b1, 0, 32'h0,
            mk(32'h11C, 32'h0020_8023, 32'h203, 32'h0, 5'd0, 1'b0, 1'b0));
      chk("sb_be", {28'h0, obs_be}, 32'h8);
      chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
      issue(32'h120, 32'h0020_A023, 32'h204, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 2, 32'h0,
            mk(32'h120, 32'h0020_A023, 32'h204, 32'h0, 5'd0, 1'b0, 1'b0));
      chk("sw_be", {28'h0, obs_be}, 32'hF);
      chk("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
      chk("sw_addr", obs_addr, 32'h204);
      chk("sw_stall", obs_stall, 3);

      // LBU top lane
      issue(32'h124, 32'h0000_C283, 32'h103, 32'h0, 5'd5, 1'b1, 1'b0, 0, 32'h8000_0000,
            mk(32'h124, 32'h0000_C283, 32'h103, 32'h0000_0080, 5'd5, 1'b1, 1'b0));

      // misaligned SH: store dropped
      issue(32'h128, 32'h0020_9023, 32'h201, 32'h1111_2222, 5'd0, 1'b0, 1'b1, -1, 32'h0,
            mk(32'h128, 32'h0020_9023, 32'h201, 32'h0, 5'd0, 1'b0, 1'b1));
      chk("sh_mis_req", obs_req, 0);
      nop(32'h0);

      // reset while a load is in REQ; a late ack must do nothing
      pc_in = 32'h130; iw_in = 32'h0000_A303; alu_in = 32'h400;
      wb_reg_in = 5'd6; wb_en_in = 1'b1; w_en_in = 1'b0;
      @(posedge clk); #1;
      chk("mid_rd_req", {31'h0, d_rd_req}, 32'h1);
      chk("mid_state", {31'h0, dbg_state}, 32'h1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst2_rd_req", {31'h0, d_rd_req}, 32'h0);
      chk("rst2_state", {31'h0, dbg_state}, 32'h0);
      chk("rst2_iw_out", iw_out, 32'h0);
      chk("rst2_pc_out", pc_out, 32'h0);
      chk("rst2_alu_out", alu_out, 32'h0);
      chk("rst2_wb_reg", {27'h0, wb_reg_out}, 32'h0);
      reset = 1'b1;
      pc_in = 32'h134; iw_in = NOP; alu_in = 32'h0; wb_reg_in = 5'd0; wb_en_in = 1'b0;
      d_ack = 1'b1; d_rdata = 32'hFFFF_FFFF;
      exp_q.push_back(mk(32'h134, NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
      @(negedge clk);
      chk("late_ack_stall", {31'h0, mem_stall}, 32'h0);
      @(posedge clk); #1;
      d_ack = 1'b0;
      chk("late_ack_rd_req", {31'h0, d_rd_req}, 32'h0);
      chk("late_ack_state", {31'h0, dbg_state}, 32'h0);

      // normal operation after reset
      issue(32'h138, 32'h0050_0193, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0, -1, 32'h0,
            mk(32'h138, 32'h0050_0193, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0));

      // park in reset so nothing else retires, then drain the monitor
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got no finish expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
